// File: rtl/ascensor_pkg.sv
// ---------------------------------------------------------------------------
// ascensor_pkg
// Shared definitions for the 4-floor elevator controller.
//   - Bit positions inside the 10-bit request vector (cabin, hall-up,
//     hall-down buttons).
//   - FSM state encoding.
//   - Helper functions that turn a floor number into request masks and
//     answer "is there anything above / below / at this floor".
// ---------------------------------------------------------------------------
package ascensor_pkg;

    // Cabin buttons, floors 0..3
    localparam int CAB0 = 0;
    localparam int CAB1 = 1;
    localparam int CAB2 = 2;
    localparam int CAB3 = 3;
    // Hall-up buttons, floors 0..2
    localparam int SUB0 = 4;
    localparam int SUB1 = 5;
    localparam int SUB2 = 6;
    // Hall-down buttons, floors 1..3
    localparam int BAJ1 = 7;
    localparam int BAJ2 = 8;
    localparam int BAJ3 = 9;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        PUERTA   = 2'd1,
        MOVIENDO = 2'd2
    } estado_fsm_t;

    // Every request bit that belongs to floor f (cabin plus both halls).
    function automatic logic [9:0] mascara_piso(input logic [1:0] f);
        logic [9:0] m;
        m = '0;
        case (f)
            2'd0: begin
                m[CAB0] = 1'b1;
                m[SUB0] = 1'b1;
            end
            2'd1: begin
                m[CAB1] = 1'b1;
                m[SUB1] = 1'b1;
                m[BAJ1] = 1'b1;
            end
            2'd2: begin
                m[CAB2] = 1'b1;
                m[SUB2] = 1'b1;
                m[BAJ2] = 1'b1;
            end
            default: begin
                m[CAB3] = 1'b1;
                m[BAJ3] = 1'b1;
            end
        endcase
        return m;
    endfunction

    // Cabin bit of floor f only.
    function automatic logic [9:0] mascara_cabina(input logic [1:0] f);
        logic [9:0] m;
        m = '0;
        case (f)
            2'd0:    m[CAB0] = 1'b1;
            2'd1:    m[CAB1] = 1'b1;
            2'd2:    m[CAB2] = 1'b1;
            default: m[CAB3] = 1'b1;
        endcase
        return m;
    endfunction

    // Hall bit at floor f that matches travel direction dir
    // (0 = up, 1 = down). Empty where that button does not exist.
    function automatic logic [9:0] mascara_sentido(input logic [1:0] f, input logic dir);
        logic [9:0] m;
        m = '0;
        if (!dir) begin
            case (f)
                2'd0:    m[SUB0] = 1'b1;
                2'd1:    m[SUB1] = 1'b1;
                2'd2:    m[SUB2] = 1'b1;
                default: m = '0;
            endcase
        end else begin
            case (f)
                2'd1:    m[BAJ1] = 1'b1;
                2'd2:    m[BAJ2] = 1'b1;
                2'd3:    m[BAJ3] = 1'b1;
                default: m = '0;
            endcase
        end
        return m;
    endfunction

    // Any request for a floor strictly above f.
    function automatic logic arriba(input logic [9:0] sol, input logic [1:0] f);
        logic [9:0] m;
        m = '0;
        for (int g = 0; g < 4; g++) begin
            if (g > int'(f)) m = m | mascara_piso(2'(g));
        end
        return |(sol & m);
    endfunction

    // Any request for a floor strictly below f.
    function automatic logic abajo(input logic [9:0] sol, input logic [1:0] f);
        logic [9:0] m;
        m = '0;
        for (int g = 0; g < 4; g++) begin
            if (g < int'(f)) m = m | mascara_piso(2'(g));
        end
        return |(sol & m);
    endfunction

    // Any request at floor f.
    function automatic logic en_piso(input logic [9:0] sol, input logic [1:0] f);
        return |(sol & mascara_piso(f));
    endfunction

endpackage

// File: rtl/temporizador_ascensor.sv
// ---------------------------------------------------------------------------
// temporizador_ascensor
// Loadable down-counter shared by the door and travel phases.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset (count returns to 0)
//   carga  - load strobe; has priority over counting
//   valor  - value loaded when carga is high
//   expira - high while the count equals 1 (last cycle of the interval)
// The counter parks at 0 when not loaded, so it never expires while idle.
// ---------------------------------------------------------------------------
module temporizador_ascensor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         carga,
    input  logic [W-1:0] valor,
    output logic         expira
);

    logic [W-1:0] cuenta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cuenta <= '0;
        end else if (carga) begin
            cuenta <= valor;
        end else if (cuenta != '0) begin
            cuenta <= cuenta - W'(1);
        end
    end

    assign expira = (cuenta == W'(1));

endmodule

// File: rtl/controlador_ascensor.sv
// ---------------------------------------------------------------------------
// controlador_ascensor
// Collective (SCAN) controller for a 4-floor elevator.
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous active-high reset
//   botones     - raw button levels: [3:0] cabin 0..3, [6:4] hall-up 0..2,
//                 [9:7] hall-down 1..3
//   solicitudes - latched pending requests, same bit map
//   estado      - {moving, dir (1 = down), floor[1:0]}
// Requests latch as (solicitudes | botones) & ~clr, where clr holds the
// bits being served in the current cycle, so serving wins over a press.
// ---------------------------------------------------------------------------
module controlador_ascensor #(
    parameter int T_PISO   = 8,
    parameter int T_PUERTA = 6,
    parameter int W_CNT    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] botones,
    output logic [9:0] solicitudes,
    output logic [3:0] estado
);

    import ascensor_pkg::*;

    localparam logic [W_CNT-1:0] CARGA_PISO   = W_CNT'(T_PISO);
    localparam logic [W_CNT-1:0] CARGA_PUERTA = W_CNT'(T_PUERTA);

    estado_fsm_t      state, state_sig;
    logic [9:0]       sol;
    logic [1:0]       floor, floor_sig, nf;
    logic             dir, dir_sig, moving, moving_sig;
    logic [9:0]       clr;
    logic             carga;
    logic [W_CNT-1:0] valor;
    logic             expira;
    logic             mas_lejos, fin_recorrido, parar;

    temporizador_ascensor #(.W(W_CNT)) u_temporizador (
        .clk    (clk),
        .reset  (reset),
        .carga  (carga),
        .valor  (valor),
        .expira (expira)
    );

    // Arrival evaluation: the floor the car is about to reach, and whether
    // it has to stop there. The clamp keeps the floor inside 0..3.
    always_comb begin
        nf = floor;
        if (!dir && floor != 2'd3) begin
            nf = floor + 2'd1;
        end else if (dir && floor != 2'd0) begin
            nf = floor - 2'd1;
        end
        mas_lejos     = dir ? abajo(sol, nf) : arriba(sol, nf);
        fin_recorrido = !mas_lejos || nf == 2'd0 || nf == 2'd3;
        parar         = fin_recorrido ||
                        (|(sol & (mascara_cabina(nf) | mascara_sentido(nf, dir))));
    end

    // Next-state decision, bits served this cycle and timer load.
    always_comb begin
        state_sig  = state;
        floor_sig  = floor;
        dir_sig    = dir;
        moving_sig = moving;
        clr        = '0;
        carga      = 1'b0;
        valor      = CARGA_PUERTA;
        case (state)
            REPOSO: begin
                if (en_piso(sol, floor)) begin
                    state_sig = PUERTA;
                    clr       = mascara_piso(floor);
                    carga     = 1'b1;
                    valor     = CARGA_PUERTA;
                end else if (dir ? abajo(sol, floor) : arriba(sol, floor)) begin
                    state_sig  = MOVIENDO;
                    moving_sig = 1'b1;
                    carga      = 1'b1;
                    valor      = CARGA_PISO;
                end else if (dir ? arriba(sol, floor) : abajo(sol, floor)) begin
                    state_sig  = MOVIENDO;
                    dir_sig    = ~dir;
                    moving_sig = 1'b1;
                    carga      = 1'b1;
                    valor      = CARGA_PISO;
                end
            end
            MOVIENDO: begin
                if (expira) begin
                    floor_sig = nf;
                    carga     = 1'b1;
                    if (parar) begin
                        state_sig  = PUERTA;
                        moving_sig = 1'b0;
                        valor      = CARGA_PUERTA;
                        clr        = mascara_cabina(nf) | mascara_sentido(nf, dir);
                        // End of run: turn around and also serve the hall
                        // call for the new direction at this floor.
                        if (fin_recorrido) begin
                            dir_sig = ~dir;
                            clr     = clr | mascara_sentido(nf, ~dir);
                        end
                    end else begin
                        valor = CARGA_PISO;
                    end
                end
            end
            PUERTA: begin
                // Presses that would just reopen this door are absorbed
                // instead of latched, and restart the door interval.
                clr = mascara_cabina(floor) | mascara_sentido(floor, dir);
                if (|(botones & clr)) begin
                    carga = 1'b1;
                    valor = CARGA_PUERTA;
                end else if (expira) begin
                    state_sig = REPOSO;
                end
            end
            default: begin
                state_sig  = REPOSO;
                moving_sig = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= REPOSO;
            sol    <= '0;
            floor  <= 2'd0;
            dir    <= 1'b0;
            moving <= 1'b0;
        end else begin
            state  <= state_sig;
            sol    <= (sol | botones) & ~clr;
            floor  <= floor_sig;
            dir    <= dir_sig;
            moving <= moving_sig;
        end
    end

    assign solicitudes = sol;
    assign estado      = {moving, dir, floor};

endmodule

// File: tb/tb_controlador_ascensor.sv
// ---------------------------------------------------------------------------
// tb_controlador_ascensor
// Directed bench for controlador_ascensor with T_PISO=4, T_PUERTA=3.
// A table of per-cycle {reset, buttons, expected requests, expected estado,
// expected FSM state} rows covers a full upward trip and an at-floor call;
// hand-written sequences cover intermediate stops, passing a floor with an
// opposite-direction call, door reopen and asynchronous reset mid-travel.
// ---------------------------------------------------------------------------
module tb_controlador_ascensor;

    localparam logic [1:0] S_REP = 2'd0;
    localparam logic [1:0] S_PUE = 2'd1;
    localparam logic [1:0] S_MOV = 2'd2;

    logic       clk;
    logic       reset;
    logic [9:0] botones;
    logic [9:0] solicitudes;
    logic [3:0] estado;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rst;
        logic [9:0] bot;
        logic [9:0] sol;
        logic [3:0] est;
        logic [1:0] fsm;
    } vec_t;

    vec_t tabla[$];

    controlador_ascensor #(
        .T_PISO   (4),
        .T_PUERTA (3),
        .W_CNT    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .botones     (botones),
        .solicitudes (solicitudes),
        .estado      (estado)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        botones = '0;
        #2;
        reset   = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic void add(input logic rst, input logic [9:0] bot, input logic [9:0] sol,
                                input logic [3:0] est, input logic [1:0] fsm);
        vec_t v;
        v.rst = rst;
        v.bot = bot;
        v.sol = sol;
        v.est = est;
        v.fsm = fsm;
        tabla.push_back(v);
    endfunction

    function automatic void add_n(input int n, input logic [9:0] sol,
                                  input logic [3:0] est, input logic [1:0] fsm);
        for (int i = 0; i < n; i++) add(1'b0, 10'h000, sol, est, fsm);
    endfunction

    // ---------------- stimulus and checks ----------------
    initial begin
        reset   = 1'b1;
        botones = '0;

        // Trip 0 -> 3 on cabin 3: depart, one floor every 4 cycles,
        // end-of-run stop at 3 turns dir to down, door closes after 3.
        add(1'b1, 10'h000, 10'h000, 4'b0000, S_REP);
        add(1'b0, 10'h008, 10'h008, 4'b0000, S_REP);
        add_n(4, 10'h008, 4'b1000, S_MOV);
        add_n(4, 10'h008, 4'b1001, S_MOV);
        add_n(4, 10'h008, 4'b1010, S_MOV);
        add_n(3, 10'h000, 4'b0111, S_PUE);
        add_n(2, 10'h000, 4'b0111, S_REP);
        // Hall-up at the idle floor: door opens without motion.
        add(1'b1, 10'h000, 10'h000, 4'b0000, S_REP);
        add(1'b0, 10'h010, 10'h010, 4'b0000, S_REP);
        add_n(3, 10'h000, 4'b0000, S_PUE);
        add_n(2, 10'h000, 4'b0000, S_REP);

        for (int i = 0; i < tabla.size(); i++) begin
            reset   = tabla[i].rst;
            botones = tabla[i].bot;
            tick();
            chk($sformatf("row%0d solicitudes", i), 32'(solicitudes), 32'(tabla[i].sol));
            chk($sformatf("row%0d estado", i), 32'(estado), 32'(tabla[i].est));
            chk($sformatf("row%0d fsm", i), 32'(dut.state), 32'(tabla[i].fsm));
        end
        reset   = 1'b0;
        botones = '0;

        // Intermediate stop on hall-up at floor 1 while heading to 3.
        do_reset();
        botones = 10'h008; tick();
        botones = 10'h000; tick();
        botones = 10'h020; tick();
        botones = 10'h000;
        chk("stop1 latched", 32'(solicitudes), 32'h028);
        repeat (3) tick();
        chk("stop1 estado", 32'(estado), 32'h1);
        chk("stop1 solicitudes", 32'(solicitudes), 32'h008);
        chk("stop1 fsm", 32'(dut.state), 32'(S_PUE));
        repeat (3) tick();
        chk("stop1 closed", 32'(dut.state), 32'(S_REP));
        tick();
        chk("stop1 resume", 32'(estado), 32'h9);
        repeat (8) tick();
        chk("stop1 arrive3 estado", 32'(estado), 32'h7);
        chk("stop1 arrive3 sol", 32'(solicitudes), 32'h000);

        // Hall-down at 2 is passed going up, served on the way back.
        do_reset();
        botones = 10'h008; tick();
        botones = 10'h000; tick();
        botones = 10'h100; tick();
        botones = 10'h000;
        chk("pass latched", 32'(solicitudes), 32'h108);
        repeat (7) tick();
        chk("pass floor2 moving", 32'(estado), 32'ha);
        repeat (4) tick();
        chk("pass arrive3 estado", 32'(estado), 32'h7);
        chk("pass arrive3 sol", 32'(solicitudes), 32'h100);
        repeat (4) tick();
        chk("pass depart down", 32'(estado), 32'hf);
        repeat (3) tick();
        chk("pass still at 3", 32'(estado), 32'hf);
        tick();
        chk("pass stop2 estado", 32'(estado), 32'h2);
        chk("pass stop2 sol", 32'(solicitudes), 32'h000);

        // Door reopen: cabin 1 pressed again on the last door cycle.
        do_reset();
        botones = 10'h002; tick();
        botones = 10'h000; tick();
        chk("reopen depart", 32'(estado), 32'h8);
        repeat (4) tick();
        chk("reopen arrive", 32'(estado), 32'h5);
        chk("reopen arrive sol", 32'(solicitudes), 32'h000);
        repeat (2) tick();
        chk("reopen timer1", 32'(dut.u_temporizador.cuenta), 32'd1);
        botones = 10'h002; tick();
        botones = 10'h000;
        chk("reopen reload", 32'(dut.u_temporizador.cuenta), 32'd3);
        chk("reopen not latched", 32'(solicitudes), 32'h000);
        chk("reopen fsm", 32'(dut.state), 32'(S_PUE));
        repeat (2) tick();
        chk("reopen still open", 32'(dut.state), 32'(S_PUE));
        tick();
        chk("reopen closed", 32'(dut.state), 32'(S_REP));

        // Asynchronous reset while travelling with requests pending.
        do_reset();
        botones = 10'h048; tick();
        botones = 10'h000; tick();
        repeat (4) tick();
        chk("areset pre", 32'(estado), 32'h9);
        tick();
        reset = 1'b1;
        #2;
        chk("areset estado", 32'(estado), 32'h0);
        chk("areset sol", 32'(solicitudes), 32'h000);
        chk("areset fsm", 32'(dut.state), 32'(S_REP));
        reset = 1'b0;
        botones = 10'h004; tick();
        botones = 10'h000;
        chk("after latch", 32'(solicitudes), 32'h004);
        chk("after idle", 32'(estado), 32'h0);
        tick();
        chk("after depart", 32'(estado), 32'h8);
        repeat (4) tick();
        chk("after floor1", 32'(estado), 32'h9);
        repeat (4) tick();
        chk("after arrive2 estado", 32'(estado), 32'h6);
        chk("after arrive2 sol", 32'(solicitudes), 32'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
